bcd_cathode_driver: RTL and testbench

Display-side consumer of the anode scan. Accepts a binary product from the multiplier over a valid/ready handshake and converts it to four BCD digits with a sequential double-dabble engine. It then drives the active-low seven-segment cathodes to match whichever digit the anode generator is currently enabling, so the multiplier result appears on the 4-digit display.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/bcd_to_seg.sv | 17 +
 rtl/bcd_cathode_driver.sv | 149 ++++++++++++++
 tb/tb_bcd_cathode_driver.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the BCD seven-segment cathode driver:
// FSM states, segment patterns, digit table and double-dabble helper.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low {g,f,e,d,c,b,a}; entry [n] is digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam int unsigned OVF_LIMIT = 9999;

    function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
        logic [15:0] r;
        r = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational decoder from one BCD nibble to an active-low segment
// pattern; non-decimal nibbles decode to blank.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (nib_i <= 4'd9) begin
            seg_o = SEG_TABLE[nib_i];
        end
    end

endmodule

// File: rtl/bcd_cathode_driver.sv
// Binary-to-BCD display driver with valid/ready input and anode-tracking
// cathode output. Optional LEADING_ZERO_BLANK_EN blanks leading zeros.
module bcd_cathode_driver
    import seg_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             bin_valid,
    output logic             bin_ready,
    input  logic [3:0]       seg_anode,
    output logic [6:0]       seg_cathode
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] OVF_LIM = BIN_W'(OVF_LIMIT);

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [15:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        disp_q, disp_d;
    logic               dovf_q, dovf_d;
    logic               rdy_q, rdy_d;
    logic [6:0]         seg_q, seg_d;

    logic [3:0]         sel_nib;
    logic               sel_vld;
    logic               sel_lz;
    logic [6:0]         dec_seg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
            dovf_q  <= 1'b0;
            rdy_q   <= 1'b1;
            seg_q   <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            dovf_q  <= dovf_d;
            rdy_q   <= rdy_d;
            seg_q   <= seg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        dovf_d  = dovf_q;
        unique case (state_q)
            IDLE: begin
                if (bin_valid) begin
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    ovf_d   = (bin_in > OVF_LIM);
                    state_d = CONV;
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {dabble_adjust(bcd_q), bin_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Value and overflow flag swap together: no partial display.
                disp_d  = bcd_q;
                dovf_d  = ovf_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_comb begin
        sel_nib = 4'd0;
        sel_vld = 1'b1;
        sel_lz  = 1'b0;
        case (seg_anode)
            4'b1110: begin
                sel_nib = disp_q[3:0];
            end
            4'b1101: begin
                sel_nib = disp_q[7:4];
                sel_lz  = (disp_q[15:8] == 8'd0);
            end
            4'b1011: begin
                sel_nib = disp_q[11:8];
                sel_lz  = (disp_q[15:12] == 4'd0);
            end
            4'b0111: begin
                sel_nib = disp_q[15:12];
                sel_lz  = 1'b1;
            end
            default: begin
                sel_vld = 1'b0;
            end
        endcase
    end

    bcd_to_seg u_dec (
        .nib_i (sel_nib),
        .seg_o (dec_seg)
    );

    always_comb begin
        seg_d = dec_seg;
        if (!sel_vld) begin
            seg_d = SEG_BLANK;
        end else if (dovf_q) begin
            seg_d = SEG_DASH;
        end
`ifdef LEADING_ZERO_BLANK_EN
        else if (sel_lz && (sel_nib == 4'd0)) begin
            seg_d = SEG_BLANK;
        end
`else
        else if (sel_lz && 1'b0) begin
            seg_d = SEG_BLANK;
        end
`endif
    end

    assign bin_ready   = rdy_q;
    assign seg_cathode = seg_q;

endmodule

// File: tb/tb_bcd_cathode_driver.sv
// Directed self-checking bench for bcd_cathode_driver.
// Honours LEADING_ZERO_BLANK_EN for the leading-zero expectations.
module tb_bcd_cathode_driver;

    logic        clk;
    logic        rst_n;
    logic [13:0] bin_in;
    logic        bin_valid;
    logic        bin_ready;
    logic [3:0]  seg_anode;
    logic [6:0]  seg_cathode;

    int checks;
    int errors;

    bcd_cathode_driver #(.BIN_W(14)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bin_in      (bin_in),
        .bin_valid   (bin_valid),
        .bin_ready   (bin_ready),
        .seg_anode   (seg_anode),
        .seg_cathode (seg_cathode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] AN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bin_ready && n < 40) begin
            tick();
            n++;
        end
        if (!bin_ready) begin
            errors++;
            $display("FAIL wait_ready: bin_ready=%0b after %0d cycles, required 1", bin_ready, n);
        end
    endtask

    // Transfer one value, then wait out conversion and LOAD.
    task automatic send(input logic [13:0] v);
        wait_ready();
        bin_in    = v;
        bin_valid = 1'b1;
        tick();
        bin_valid = 1'b0;
        repeat (15) tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bin_valid = 1'b0;
        bin_in    = '0;
        seg_anode = 4'b1110;
        repeat (3) tick();
        checks++;
        if (seg_cathode !== 7'h7F) begin
            errors++;
            $display("FAIL reset_cathode: got %h, required 7f", seg_cathode);
        end
        checks++;
        if (bin_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1", bin_ready);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (seg_cathode !== 7'h40) begin
            errors++;
            $display("FAIL post_reset_ones: got %h, required 40", seg_cathode);
        end
        checks++;
        if (bin_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b, required 1", bin_ready);
        end
    endtask

    task automatic test_busy_ignore();
        logic [6:0] exp [4];
        int low;
        exp = '{7'h19, 7'h30, 7'h24, 7'h79};
        wait_ready();
        bin_in    = 14'd1234;
        bin_valid = 1'b1;
        tick();
        bin_in = 14'd5678;
        low = 0;
        for (int i = 0; i < 15; i++) begin
            if (bin_ready === 1'b0) low++;
            if (i < 14) tick();
        end
        checks++;
        if (low !== 15) begin
            errors++;
            $display("FAIL busy_ready_low: got %0d low cycles, required 15", low);
        end
        tick();
        checks++;
        if (bin_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_load: got %b, required 1", bin_ready);
        end
        bin_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seg_anode = AN[i];
            tick();
            checks++;
            if (seg_cathode !== exp[i]) begin
                errors++;
                $display("FAIL v1234_digit%0d: got %h, required %h", i, seg_cathode, exp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        send(14'd12000);
        for (int i = 0; i < 4; i++) begin
            seg_anode = AN[i];
            tick();
            checks++;
            if (seg_cathode !== 7'h3F) begin
                errors++;
                $display("FAIL ovf_digit%0d: got %h, required 3f", i, seg_cathode);
            end
        end
        send(14'd9999);
        for (int i = 0; i < 4; i++) begin
            seg_anode = AN[i];
            tick();
            checks++;
            if (seg_cathode !== 7'h10) begin
                errors++;
                $display("FAIL v9999_digit%0d: got %h, required 10", i, seg_cathode);
            end
        end
    endtask

    task automatic test_reset_mid_conv();
        logic [6:0] exp [4];
        exp = '{7'h40, LZ, LZ, LZ};
        wait_ready();
        bin_in    = 14'd4321;
        bin_valid = 1'b1;
        tick();
        bin_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bin_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: got %b, required 1", bin_ready);
        end
        repeat (16) tick();
        for (int i = 0; i < 4; i++) begin
            seg_anode = AN[i];
            tick();
            checks++;
            if (seg_cathode !== exp[i]) begin
                errors++;
                $display("FAIL midreset_digit%0d: got %h, required %h", i, seg_cathode, exp[i]);
            end
        end
    endtask

    task automatic test_bad_anode();
        logic [3:0] pats [3];
        pats = '{4'b1111, 4'b1100, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            seg_anode = pats[i];
            tick();
            checks++;
            if (seg_cathode !== 7'h7F) begin
                errors++;
                $display("FAIL bad_anode_%b: got %h, required 7f", pats[i], seg_cathode);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] exp [4];
        exp = '{7'h78, LZ, LZ, LZ};
        send(14'd7);
        for (int i = 0; i < 4; i++) begin
            seg_anode = AN[i];
            tick();
            checks++;
            if (seg_cathode !== exp[i]) begin
                errors++;
                $display("FAIL v7_digit%0d: got %h, required %h", i, seg_cathode, exp[i]);
            end
        end
        exp = '{7'h40, 7'h79, LZ, LZ};
        send(14'd10);
        for (int i = 0; i < 4; i++) begin
            seg_anode = AN[i];
            tick();
            checks++;
            if (seg_cathode !== exp[i]) begin
                errors++;
                $display("FAIL v10_digit%0d: got %h, required %h", i, seg_cathode, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        wait_ready();
        bin_in    = 14'd305;
        bin_valid = 1'b1;
        tick();
        bin_in = 14'd86;
        gap = 1;
        while (!bin_ready && gap < 40) begin
            tick();
            gap++;
        end
        tick();
        bin_valid = 1'b0;
        checks++;
        if (gap !== 16) begin
            errors++;
            $display("FAIL b2b_gap: got %0d cycles, required 16", gap);
        end
        repeat (15) tick();
        seg_anode = AN[1];
        tick();
        checks++;
        if (seg_cathode !== 7'h00) begin
            errors++;
            $display("FAIL b2b_tens: got %h, required 00", seg_cathode);
        end
        seg_anode = AN[0];
        tick();
        checks++;
        if (seg_cathode !== 7'h02) begin
            errors++;
            $display("FAIL b2b_ones: got %h, required 02", seg_cathode);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_busy_ignore();
        test_overflow();
        test_reset_mid_conv();
        test_bad_anode();
        test_leading_zero();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
